// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//
// Multi-cycle radix-2 restoring divider for the RISC-V M-extension ops
// DIV, DIVU, REM and REMU. It sits beside the EX-stage ALU, takes the same
// operands, and holds the pipeline via busy until the result is ready.
// The normal path retires one quotient bit per clock.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous, active-high reset
//   start   - request pulse, only honoured in IDLE
//   kill    - pipeline flush, aborts any operation (wins over start)
//   op      - 00 DIV, 01 DIVU, 10 REM, 11 REMU (latched at start)
//   a_in    - dividend (latched at start)
//   b_in    - divisor  (latched at start)
//   busy    - high whenever the FSM is not in IDLE
//   done    - one-cycle pulse, result/dbz valid in that cycle
//   result  - quotient or remainder, held until the next completion
//   dbz     - divide-by-zero flag, updated at every completion
//
// Build option:
//   DIV_EARLY_OUT_EN - when defined, operands whose dividend magnitude is
//   below the divisor magnitude finish in one cycle. Results are identical
//   with or without it; only the latency changes.
// ---------------------------------------------------------------------------
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             kill,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             dbz
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state_q,    state_d;
   logic [WIDTH-1:0]   rem_q,      rem_d;
   logic [WIDTH-1:0]   dvd_q,      dvd_d;
   logic [WIDTH-1:0]   dvs_q,      dvs_d;
   logic [WIDTH-1:0]   result_q,   result_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic               neg_quo_q,  neg_quo_d;
   logic               neg_rem_q,  neg_rem_d;
   logic               is_rem_q,   is_rem_d;
   logic               dbz_q,      dbz_d;

   logic               is_signed;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               early_out;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_diff;
   logic               fits;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Operand conditioning for the start cycle: signed ops divide magnitudes
   // and restore the signs in FIX. op[0] is only needed here, so only op[1]
   // (quotient vs remainder) is kept once the operation is running.
   assign is_signed = ~op[0];
   assign a_neg     = is_signed & a_in[WIDTH-1];
   assign b_neg     = is_signed & b_in[WIDTH-1];
   assign a_mag     = a_neg ? (-a_in) : a_in;
   assign b_mag     = b_neg ? (-b_in) : b_in;

`ifdef DIV_EARLY_OUT_EN
   // Quotient is zero and remainder is the dividend itself when the
   // dividend magnitude is already smaller than the divisor magnitude.
   assign early_out = (a_mag < b_mag);
`else
   assign early_out = 1'b0;
`endif

   // One restoring step: bring in the next dividend bit, then trial-subtract
   // the divisor with one guard bit so a borrow is visible in the MSB.
   assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, dvs_q};
   assign fits      = ~rem_diff[WIDTH];

   // Sign restoration applied in FIX.
   assign quo_fix = neg_quo_q ? (-dvd_q) : dvd_q;
   assign rem_fix = neg_rem_q ? (-rem_q) : rem_q;

   // Next-state and datapath logic. The dividend register doubles as the
   // quotient register: dividend bits shift out the top while quotient bits
   // shift in at the bottom.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      is_rem_d  = is_rem_q;
      dbz_d     = dbz_q;

      case (state_q)
         IDLE: begin
            if (start && !kill) begin
               is_rem_d = op[1];
               if (b_in == '0) begin
                  result_d = op[1] ? a_in : '1;
                  dbz_d    = 1'b1;
                  state_d  = DONE;
               end else if (is_signed && (a_in == MOST_NEG) && (b_in == '1)) begin
                  result_d = op[1] ? '0 : MOST_NEG;
                  dbz_d    = 1'b0;
                  state_d  = DONE;
               end else if (early_out) begin
                  result_d = op[1] ? a_in : '0;
                  dbz_d    = 1'b0;
                  state_d  = DONE;
               end else begin
                  dvd_d     = a_mag;
                  dvs_d     = b_mag;
                  neg_quo_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  rem_d     = '0;
                  cnt_d     = CNT_W'(WIDTH - 1);
                  state_d   = CALC;
               end
            end
         end
         CALC: begin
            rem_d = fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], fits};
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIX: begin
            result_d = is_rem_q ? rem_fix : quo_fix;
            dbz_d    = 1'b0;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A flush abandons the operation without touching the visible result.
      if (kill) begin
         state_d  = IDLE;
         result_d = result_q;
         dbz_d    = dbz_q;
      end
   end

   // State and datapath registers, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         is_rem_q  <= is_rem_d;
         dbz_q     <= dbz_d;
      end
   end

   // Status outputs decode straight from the registered state.
   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign dbz    = dbz_q;

endmodule
